// File: rtl/yonga_can_tx_scheduler.sv
// Multi-mailbox CAN transmit scheduler: lowest-ID arbitration, retry and abort handling.
// Define CAN_SCHED_TIMEOUT_EN to add a WAIT watchdog that turns a silent core into a tx failure.
module yonga_can_tx_scheduler #(
    parameter int NUM_MB      = 4,
    parameter int MB_SEL_W    = 2,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mb_wr_en,
    input  logic [MB_SEL_W-1:0] mb_wr_sel,
    input  logic [1:0]          mb_wr_field,
    input  logic [31:0]         mb_wr_data,
    input  logic [NUM_MB-1:0]   mb_req_set,
    input  logic [NUM_MB-1:0]   mb_abort,
    input  logic [NUM_MB-1:0]   mb_flag_clr,
    output logic [NUM_MB-1:0]   mb_pending,
    output logic [NUM_MB-1:0]   mb_done,
    output logic [NUM_MB-1:0]   mb_fail,
    output logic                busy,
    output logic [MB_SEL_W-1:0] active_mb,
    output logic [31:0]         core_msg_id,
    output logic [31:0]         core_msg_cfg,
    output logic [31:0]         core_data1,
    output logic [31:0]         core_data2,
    output logic                core_send,
    input  logic [2:0]          core_sts_code
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_SEND   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_UPDATE = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [MB_SEL_W-1:0] active_q, active_d;
    logic [31:0]         id_q [NUM_MB];
    logic [31:0]         id_d [NUM_MB];
    logic [31:0]         cfg_q [NUM_MB];
    logic [31:0]         cfg_d [NUM_MB];
    logic [31:0]         d1_q [NUM_MB];
    logic [31:0]         d1_d [NUM_MB];
    logic [31:0]         d2_q [NUM_MB];
    logic [31:0]         d2_d [NUM_MB];
    logic [3:0]          retry_q [NUM_MB];
    logic [3:0]          retry_d [NUM_MB];
    logic [NUM_MB-1:0]   pend_q, pend_d;
    logic [NUM_MB-1:0]   done_q, done_d;
    logic [NUM_MB-1:0]   fail_q, fail_d;
    logic                abort_req_q, abort_req_d;
    logic [2:0]          sts_q, sts_d;
    logic [31:0]         sh_id_q, sh_id_d;
    logic [31:0]         sh_cfg_q, sh_cfg_d;
    logic [31:0]         sh_d1_q, sh_d1_d;
    logic [31:0]         sh_d2_q, sh_d2_d;
    logic                send_q, send_d;
    logic                busy_w;
    logic                tmo_hit;
    logic [MB_SEL_W-1:0] win_idx;
    logic                win_vld;
    logic [29:0]         win_id;

    assign busy_w = (state_q != S_IDLE);

    // Strict less-than keeps ties on the lowest index
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (pend_q[i] && (!win_vld || id_q[i][29:0] < win_id)) begin
                win_vld = 1'b1;
                win_idx = MB_SEL_W'(i);
                win_id  = id_q[i][29:0];
            end
        end
    end

`ifdef CAN_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d   = (state_q == S_WAIT) ? tmo_q + 1'b1 : '0;
        tmo_hit = (state_q == S_WAIT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        id_d        = id_q;
        cfg_d       = cfg_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        retry_d     = retry_q;
        pend_d      = pend_q;
        done_d      = done_q & ~mb_flag_clr;
        fail_d      = fail_q & ~mb_flag_clr;
        abort_req_d = abort_req_q;
        sts_d       = sts_q;
        sh_id_d     = sh_id_q;
        sh_cfg_d    = sh_cfg_q;
        sh_d1_d     = sh_d1_q;
        sh_d2_d     = sh_d2_q;
        send_d      = 1'b0;

        if (mb_wr_en && int'(mb_wr_sel) < NUM_MB
            && !(busy_w && mb_wr_sel == active_q)) begin
            unique case (mb_wr_field)
                2'd0: id_d[mb_wr_sel]  = mb_wr_data;
                2'd1: cfg_d[mb_wr_sel] = mb_wr_data;
                2'd2: d1_d[mb_wr_sel]  = mb_wr_data;
                2'd3: d2_d[mb_wr_sel]  = mb_wr_data;
                default: ;
            endcase
        end

        for (int i = 0; i < NUM_MB; i++) begin
            if (mb_abort[i]) begin
                if (busy_w && active_q == MB_SEL_W'(i)) begin
                    abort_req_d = 1'b1;
                end else begin
                    pend_d[i] = 1'b0;
                    fail_d[i] = 1'b1;
                end
            end else if (mb_req_set[i]
                         && !(busy_w && active_q == MB_SEL_W'(i))) begin
                pend_d[i]  = 1'b1;
                retry_d[i] = '0;
            end
        end

        unique case (state_q)
            S_IDLE: if (|pend_q) state_d = S_SELECT;
            S_SELECT: begin
                if (win_vld) begin
                    active_d = win_idx;
                    state_d  = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                sh_id_d  = id_q[active_q];
                sh_cfg_d = cfg_q[active_q];
                sh_d1_d  = d1_q[active_q];
                sh_d2_d  = d2_q[active_q];
                send_d   = 1'b1;
                state_d  = S_SEND;
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (core_sts_code != 3'd0) begin
                    sts_d   = core_sts_code;
                    state_d = S_UPDATE;
                end else if (tmo_hit) begin
                    sts_d   = 3'd7;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (sts_q == 3'd1) begin
                    pend_d[active_q] = 1'b0;
                    done_d[active_q] = 1'b1;
                end else begin
                    if (sts_q != 3'd2) begin
                        retry_d[active_q] = retry_q[active_q] + 4'd1;
                        if (retry_d[active_q] >= 4'(MAX_RETRY)) begin
                            pend_d[active_q] = 1'b0;
                            fail_d[active_q] = 1'b1;
                        end
                    end
                    if (abort_req_q || mb_abort[active_q]) begin
                        pend_d[active_q] = 1'b0;
                        fail_d[active_q] = 1'b1;
                    end
                end
                abort_req_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            active_q    <= '0;
            pend_q      <= '0;
            done_q      <= '0;
            fail_q      <= '0;
            abort_req_q <= 1'b0;
            sts_q       <= '0;
            sh_id_q     <= '0;
            sh_cfg_q    <= '0;
            sh_d1_q     <= '0;
            sh_d2_q     <= '0;
            send_q      <= 1'b0;
            for (int i = 0; i < NUM_MB; i++) begin
                id_q[i]    <= '0;
                cfg_q[i]   <= '0;
                d1_q[i]    <= '0;
                d2_q[i]    <= '0;
                retry_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            abort_req_q <= abort_req_d;
            sts_q       <= sts_d;
            sh_id_q     <= sh_id_d;
            sh_cfg_q    <= sh_cfg_d;
            sh_d1_q     <= sh_d1_d;
            sh_d2_q     <= sh_d2_d;
            send_q      <= send_d;
            id_q        <= id_d;
            cfg_q       <= cfg_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            retry_q     <= retry_d;
        end
    end

    assign mb_pending   = pend_q;
    assign mb_done      = done_q;
    assign mb_fail      = fail_q;
    assign busy         = busy_w;
    assign active_mb    = active_q;
    assign core_msg_id  = sh_id_q;
    assign core_msg_cfg = sh_cfg_q;
    assign core_data1   = sh_d1_q;
    assign core_data2   = sh_d2_q;
    assign core_send    = send_q;
endmodule
